// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

    typedef enum logic {
        S_FETCH,
        S_DRAIN
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR  = 32'h0;
    localparam int          PC_STEP    = 4;
    localparam int          IFU_ADDR_W = 32;
    localparam int          IFU_DATA_W = 32;

    typedef struct packed {
        logic [IFU_ADDR_W-1:0] pc;
        logic [IFU_DATA_W-1:0] instr;
    } ifu_entry_t;

endpackage

// File: rtl/ifu_if.sv
// Fetch-unit bus bundle: memory read port, decode handshake and redirect.
interface ifu_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_rsp_valid;
    logic [DATA_W-1:0] mem_rsp_data;
    logic              if_valid;
    logic              if_ready;
    logic [DATA_W-1:0] if_instr;
    logic [ADDR_W-1:0] if_pc;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;

    modport master (
        output mem_req_valid, mem_req_addr, if_valid, if_instr, if_pc,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data, if_ready,
               redirect_valid, redirect_pc
    );

    modport slave (
        input  mem_req_valid, mem_req_addr, if_valid, if_instr, if_pc,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data, if_ready,
               redirect_valid, redirect_pc
    );
endinterface

// File: rtl/ifu_fifo.sv
// Synchronous FIFO of a parameterised entry type; flush beats push and pop.
module ifu_fifo
    import ifu_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = ifu_entry_t
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  T                       wdata_i,
    output T                       rdata_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    T                mem_q [DEPTH];
    logic [PW-1:0]   rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            empty, full, do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CW'(DEPTH));
    assign do_pop  = pop_i & ~empty;
    // A full FIFO may still take a push when the head leaves the same cycle.
    assign do_push = push_i & (~full | do_pop);

    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + PW'(1);
            if (do_pop)  rd_d = rd_q + PW'(1);
            cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: credit-limited sequential requests, prefetch FIFO, redirect drain.
// Build option IFU_BYPASS_EN lets a response reach decode in its arrival cycle.
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic  clk,
    input  logic  reset,
    ifu_if.master bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = CW + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } entry_t;

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]     discard_q, discard_d;
    logic [CW-1:0]     fifo_cnt, outst_cnt, outst_nxt;
    logic [SW-1:0]     credit_used;
    logic              req_fire, rsp_drop, fifo_push, fifo_pop, fifo_empty, bypass_hit;
    logic [ADDR_W-1:0] tag_head;
    entry_t            fifo_head, rsp_entry, head;

    // Every accepted request owns a FIFO slot, so responses never need backpressure.
    assign credit_used       = {1'b0, outst_cnt} + {1'b0, fifo_cnt};
    assign bus.mem_req_valid = ~reset & ~bus.redirect_valid & (state_q == S_FETCH)
                             & (credit_used < SW'(FIFO_DEPTH));
    assign bus.mem_req_addr  = fetch_pc_q;
    assign req_fire          = bus.mem_req_valid & bus.mem_req_ready;

    assign rsp_drop   = bus.redirect_valid | (discard_q != '0);
    assign rsp_entry  = {tag_head, bus.mem_rsp_data};
    assign fifo_empty = (fifo_cnt == '0);

`ifdef IFU_BYPASS_EN
    assign bypass_hit   = ~reset & fifo_empty & bus.mem_rsp_valid & ~rsp_drop;
    assign bus.if_valid = ~fifo_empty | bypass_hit;
    assign head         = fifo_empty ? rsp_entry : fifo_head;
`else
    assign bypass_hit   = 1'b0;
    assign bus.if_valid = ~fifo_empty;
    assign head         = fifo_head;
`endif

    assign fifo_push    = bus.mem_rsp_valid & ~rsp_drop & ~(bypass_hit & bus.if_ready);
    assign fifo_pop     = ~fifo_empty & bus.if_ready;
    assign bus.if_instr = bus.if_valid ? head.instr : DATA_W'(NOP_INSTR);
    assign bus.if_pc    = bus.if_valid ? head.pc : '0;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        discard_d  = discard_q;
        outst_nxt  = outst_cnt + CW'(req_fire) - CW'(bus.mem_rsp_valid);
        if (bus.mem_rsp_valid && discard_q != '0) discard_d = discard_q - CW'(1);
        if (req_fire) fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
        if (state_q == S_DRAIN && discard_q == '0) state_d = S_FETCH;
        // Everything still in flight after this cycle belongs to the old path.
        if (bus.redirect_valid) begin
            fetch_pc_d = bus.redirect_pc & ~ADDR_W'(3);
            discard_d  = outst_nxt;
            state_d    = (outst_nxt != '0) ? S_DRAIN : S_FETCH;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_FETCH;
            fetch_pc_q <= RESET_PC;
            discard_q  <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            discard_q  <= discard_d;
        end
    end

    ifu_fifo #(.DEPTH(FIFO_DEPTH), .T(entry_t)) u_ifq (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .flush_i (bus.redirect_valid),
        .wdata_i (rsp_entry),
        .rdata_o (fifo_head),
        .count_o (fifo_cnt)
    );

    // PC tags survive a redirect: discarded responses still retire their tag.
    ifu_fifo #(.DEPTH(FIFO_DEPTH), .T(logic [ADDR_W-1:0])) u_tagq (
        .clk     (clk),
        .reset   (reset),
        .push_i  (req_fire),
        .pop_i   (bus.mem_rsp_valid),
        .flush_i (1'b0),
        .wdata_i (fetch_pc_q),
        .rdata_o (tag_head),
        .count_o (outst_cnt)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomised bench for instr_fetch_unit against a queue-based model of the fetch contract.
module tb_instr_fetch_unit;
    import ifu_pkg::*;

    localparam int DEPTH = 4;
`ifdef IFU_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ifu_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    ifu_if #(.ADDR_W(32), .DATA_W(32)) bus_w ();

    instr_fetch_unit #(.ADDR_W(32), .DATA_W(32), .FIFO_DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset), .bus(bus));
    instr_fetch_unit #(.ADDR_W(32), .DATA_W(32), .FIFO_DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut_w (
        .clk(clk), .reset(reset), .bus(bus_w));

    int n_chk = 0, n_pass = 0, n_fail = 0;
    logic [31:0] prog [64];
    logic [31:0] inflight [$];
    logic [63:0] buffered [$];
    logic [31:0] pops [$];
    logic [31:0] m_pc;
    int          to_discard;
    bit          draining;
    int          p_rdy, p_rsp, p_ifr, p_redir;
    bit          force_redir;
    logic [31:0] redir_tgt;
    bit          req_seen, pop_seen, last_ifv;
    logic [31:0] last_req_addr, last_pop_pc;
    logic [31:0] w_addr [3];
    int          wn = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] memword(input logic [31:0] a);
        return prog[a[7:2]];
    endfunction

    task automatic model_reset();
        inflight.delete();
        buffered.delete();
        m_pc = 32'h0;
        to_discard = 0;
        draining = 1'b0;
    endtask

    task automatic idle_inputs();
        bus.mem_req_ready  = 1'b0;
        bus.mem_rsp_valid  = 1'b0;
        bus.mem_rsp_data   = 32'h0;
        bus.if_ready       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
    endtask

    task automatic reset_outputs(input string t);
        check({t, "_req_valid"}, bus.mem_req_valid, 32'h0);
        check({t, "_req_addr"},  bus.mem_req_addr,  32'h0);
        check({t, "_if_valid"},  bus.if_valid,      32'h0);
        check({t, "_if_instr"},  bus.if_instr,      32'h0);
        check({t, "_if_pc"},     bus.if_pc,         32'h0);
        check({t, "_w_addr"},    bus_w.mem_req_addr, 32'hFFFF_FFF8);
    endtask

    // One clock: drive at negedge, check at negedge+1, then advance the model.
    task automatic step();
        bit rsp, redir, acc, popd, byp, exp_rv, exp_iv, dr0;
        int disc0;
        logic [31:0] hpc, hin, a;
        @(negedge clk);
        redir = force_redir || (($urandom % 100) < p_redir);
        bus.redirect_valid = redir;
        bus.redirect_pc    = force_redir ? redir_tgt : ($urandom & 32'hFF);
        bus.mem_req_ready  = ($urandom % 100) < p_rdy;
        rsp = (inflight.size() > 0) && (($urandom % 100) < p_rsp);
        bus.mem_rsp_valid  = rsp;
        bus.mem_rsp_data   = rsp ? memword(inflight[0]) : $urandom;
        bus.if_ready       = ($urandom % 100) < p_ifr;
        #1;
        disc0 = to_discard;
        dr0   = draining;
        exp_rv = !draining && !redir && (inflight.size() + buffered.size() < DEPTH);
        check("req_valid", bus.mem_req_valid, exp_rv);
        if (exp_rv) check("req_addr", bus.mem_req_addr, m_pc);
        byp = BYP && buffered.size() == 0 && rsp && to_discard == 0 && !redir;
        exp_iv = (buffered.size() > 0) || byp;
        check("if_valid", bus.if_valid, exp_iv);
        hpc = 32'h0;
        hin = 32'h0;
        if (buffered.size() > 0) {hpc, hin} = buffered[0];
        else if (byp) begin
            hpc = inflight[0];
            hin = memword(hpc);
        end
        if (exp_iv) begin
            check("if_pc", bus.if_pc, hpc);
            check("if_instr", bus.if_instr, hin);
        end
        last_ifv = bus.if_valid;
        if (bus.mem_req_valid) begin
            req_seen = 1'b1;
            last_req_addr = bus.mem_req_addr;
        end
        acc  = exp_rv && bus.mem_req_ready;
        popd = exp_iv && bus.if_ready;
        if (popd) begin
            pops.push_back(hpc);
            pop_seen = 1'b1;
            last_pop_pc = hpc;
            if (buffered.size() > 0) void'(buffered.pop_front());
        end
        if (rsp) begin
            a = inflight.pop_front();
            if (to_discard > 0) to_discard--;
            else if (!redir && !(byp && bus.if_ready)) buffered.push_back({a, memword(a)});
        end
        if (acc) begin
            inflight.push_back(m_pc);
            m_pc += 32'd4;
        end
        if (dr0 && disc0 == 0) draining = 1'b0;
        if (redir) begin
            buffered.delete();
            to_discard = inflight.size();
            draining = (to_discard > 0);
            m_pc = bus.redirect_pc & ~32'h3;
        end
    endtask

    task automatic set_knobs(input int rdy, input int rs, input int ifr, input int rd);
        p_rdy = rdy; p_rsp = rs; p_ifr = ifr; p_redir = rd;
    endtask

    // Wrap instance: always ready, never responds; log its first three requests.
    always @(negedge clk) begin
        #1;
        if (!reset && bus_w.mem_req_valid && bus_w.mem_req_ready && wn < 3) begin
            w_addr[wn] = bus_w.mem_req_addr;
            wn++;
        end
    end

    initial begin
        int breaks;
        for (int i = 0; i < 64; i++) prog[i] = $urandom;
        idle_inputs();
        bus_w.mem_req_ready = 1'b1;  bus_w.mem_rsp_valid = 1'b0; bus_w.mem_rsp_data = 32'h0;
        bus_w.if_ready = 1'b0;       bus_w.redirect_valid = 1'b0; bus_w.redirect_pc = 32'h0;
        force_redir = 1'b0; redir_tgt = 32'h0;
        model_reset();
        #12;
        reset_outputs("rst");
        @(negedge clk);
        reset = 1'b0;

        // Straight-line fetch, memory and decode always ready.
        set_knobs(100, 100, 100, 0);
        pops.delete();
        step();
        step();
        check("first_rsp_same_cycle_valid", last_ifv, BYP);
        for (int i = 0; i < 12; i++) step();
        check("t1_npops", pops.size() >= 7, 1);
        for (int i = 0; i < 7 && i < pops.size(); i++) check("t1_pop_pc", pops[i], i * 4);

        // Decode stall fills the credit window, then release.
        set_knobs(100, 100, 0, 0);
        for (int i = 0; i < 10; i++) step();
        check("t2_stall_no_req", bus.mem_req_valid, 0);
        check("t2_stall_valid", bus.if_valid, 1);
        set_knobs(100, 100, 100, 0);
        for (int i = 0; i < 12; i++) step();
        breaks = 0;
        for (int i = 1; i < pops.size(); i++) if (pops[i] != pops[i-1] + 32'd4) breaks++;
        check("t2_seq_breaks", breaks, 0);

        // Redirect with exactly two requests in flight.
        set_knobs(0, 100, 100, 0);
        for (int i = 0; i < 8; i++) step();
        set_knobs(100, 0, 100, 0);
        step();
        step();
        set_knobs(0, 0, 100, 0);
        force_redir = 1'b1; redir_tgt = 32'h40;
        step();
        force_redir = 1'b0;
        set_knobs(100, 100, 100, 0);
        step();
        check("t3_drain_no_req", bus.mem_req_valid, 0);
        pop_seen = 1'b0;
        for (int i = 0; i < 20 && !pop_seen; i++) step();
        check("t3_pop_seen", pop_seen, 1);
        check("t3_first_pc", last_pop_pc, 32'h40);

        // Redirect to an unaligned target while a response and a pop coincide.
        for (int i = 0; i < 10; i++) step();
        force_redir = 1'b1; redir_tgt = 32'h43;
        step();
        force_redir = 1'b0;
        check("t4_pop_in_redirect", last_ifv, 1);
        req_seen = 1'b0;
        for (int i = 0; i < 10 && !req_seen; i++) step();
        check("t4_req_seen", req_seen, 1);
        check("t4_req_addr", last_req_addr, 32'h40);
        pop_seen = 1'b0;
        for (int i = 0; i < 20 && !pop_seen; i++) step();
        check("t4_first_pc", last_pop_pc, 32'h40);

        // Asynchronous reset between clock edges, mid-burst.
        for (int i = 0; i < 6; i++) step();
        @(posedge clk);
        #3;
        reset = 1'b1;
        idle_inputs();
        #1;
        reset_outputs("async");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        req_seen = 1'b0;
        for (int i = 0; i < 5 && !req_seen; i++) step();
        check("t5_req_seen", req_seen, 1);
        check("t5_req_addr", last_req_addr, 32'h0);

        // Randomised traffic with random redirects.
        for (int blk = 0; blk < 8; blk++) begin
            set_knobs($urandom_range(100, 30), $urandom_range(100, 30),
                      $urandom_range(100, 20), $urandom_range(8, 0));
            for (int i = 0; i < 50; i++) step();
        end

        // PC wrap on the second instance.
        check("t6_wrap_count", wn, 3);
        if (wn == 3) begin
            check("t6_wrap0", w_addr[0], 32'hFFFF_FFF8);
            check("t6_wrap1", w_addr[1], 32'hFFFF_FFFC);
            check("t6_wrap2", w_addr[2], 32'h0000_0000);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
